// File: rtl/common_pkg.sv
// Shared types for the DPLL core: formula word, formula-stack sizing and
// the backtrack controller state encoding.
package common;

    // Formula-stack geometry; DEPTH_W indexes levels, counters are DEPTH_W+1 bits
    localparam int formula_stack_size       = 8;
    localparam int width_formula_stack_size = 3;

    // A formula snapshot as stored on the formula stack
    localparam int FORMULA_W = 16;
    typedef logic [FORMULA_W-1:0] formula;
    localparam formula zero_formula = '0;

    // Backtrack controller states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        POP     = 3'd1,
        WAIT    = 3'd2,
        RESTORE = 3'd3,
        UNSAT   = 3'd4
    } bt_state_t;

endpackage

// File: rtl/branch_flag_stack.sv
// One "second branch already tried" bit per decision level. Written at the
// level being pushed, read combinationally at the topmost occupied level.
module branch_flag_stack #(
    parameter int DEPTH   = 8,
    parameter int DEPTH_W = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [DEPTH_W-1:0] wr_idx,
    input  logic               wr_bit,
    input  logic [DEPTH_W-1:0] rd_idx,
    output logic               rd_bit
);

    logic [DEPTH-1:0] flags_q;

    // Flag storage; stale bits above the current level are simply overwritten on the next push
    always_ff @(posedge clock) begin
        if (!reset) begin
            flags_q <= '0;
        end else if (wr_en) begin
            flags_q[wr_idx] <= wr_bit;
        end
    end

    assign rd_bit = flags_q[rd_idx];

endmodule

// File: rtl/backtrack_ctrl.sv
// Read-side backtrack controller for the DPLL formula stack. Tracks the
// decision level, pops on conflict until an open level is found, then hands
// the restored formula back to the solver or declares UNSAT.
//
// Handshake: decide and conflict are single-cycle strobes accepted only in
// IDLE; stack_pop is a one-cycle request and stack_dout is valid the
// following cycle; restore_valid is a one-cycle strobe qualifying
// restored_formula and restore_level.
module backtrack_ctrl
    import common::*;
#(
    parameter int DEPTH   = formula_stack_size,
    parameter int DEPTH_W = width_formula_stack_size
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             decide,
    input  logic             decide_second,
    input  logic             conflict,
    input  logic             stack_empty,
    input  formula           stack_dout,
    output logic             stack_pop,
    output logic             restore_valid,
    output formula           restored_formula,
    output logic [DEPTH_W:0] restore_level,
    output logic [DEPTH_W:0] depth,
    output logic             busy,
    output logic             unsat,
    output logic             protocol_err,
    output logic [2:0]       dbg_state
);

    localparam logic [DEPTH_W:0] LVL_ONE  = {{DEPTH_W{1'b0}}, 1'b1};
    localparam logic [DEPTH_W:0] LVL_ZERO = '0;
    localparam logic [DEPTH_W:0] LVL_MAX  = (DEPTH_W+1)'(DEPTH);

    bt_state_t        state_q;
    logic [DEPTH_W:0] depth_q;
    logic [DEPTH_W:0] depth_m1;
    logic             tried_q;
    formula           formula_q;
    logic             restore_valid_q;
    logic [DEPTH_W:0] restore_level_q;
    logic             perr_q;

    logic             push_ok;
    logic             flag_rd;

    // A push is accepted only in IDLE, without a concurrent conflict, below saturation
    assign push_ok  = (state_q == IDLE) && decide && !conflict && (depth_q < LVL_MAX);
    assign depth_m1 = depth_q - LVL_ONE;

    branch_flag_stack #(
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W)
    ) u_flags (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (push_ok),
        .wr_idx (depth_q[DEPTH_W-1:0]),
        .wr_bit (decide_second),
        .rd_idx (depth_m1[DEPTH_W-1:0]),
        .rd_bit (flag_rd)
    );

    // Backtrack FSM with level counter, captured formula and sticky error
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= IDLE;
            depth_q         <= LVL_ZERO;
            tried_q         <= 1'b0;
            formula_q       <= zero_formula;
            restore_valid_q <= 1'b0;
            restore_level_q <= LVL_ZERO;
            perr_q          <= 1'b0;
        end else begin
            restore_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (conflict) begin
                        // Conflict wins; a simultaneous push cannot be honoured
                        if (decide) begin
                            perr_q <= 1'b1;
                        end
                        state_q <= (depth_q == LVL_ZERO) ? UNSAT : POP;
                    end else if (decide) begin
                        if (depth_q < LVL_MAX) begin
                            depth_q <= depth_q + LVL_ONE;
                        end else begin
                            perr_q <= 1'b1;
                        end
                    end
                end
                POP: begin
                    if (decide || conflict) begin
                        perr_q <= 1'b1;
                    end
                    depth_q <= depth_m1;
                    tried_q <= flag_rd;
                    // Stack disagrees with our level count: give up rather than pop empty
                    if (stack_empty) begin
                        perr_q  <= 1'b1;
                        state_q <= UNSAT;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (decide || conflict) begin
                        perr_q <= 1'b1;
                    end
                    formula_q <= stack_dout;
                    if (!tried_q) begin
                        state_q         <= RESTORE;
                        restore_valid_q <= 1'b1;
                        restore_level_q <= depth_q;
                    end else if (depth_q == LVL_ZERO) begin
                        state_q <= UNSAT;
                    end else begin
                        state_q <= POP;
                    end
                end
                RESTORE: begin
                    if (decide || conflict) begin
                        perr_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                UNSAT: begin
                    state_q <= UNSAT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stack_pop        = (state_q == POP) && !stack_empty;
    assign restore_valid    = restore_valid_q;
    assign restored_formula = formula_q;
    assign restore_level    = restore_level_q;
    assign depth            = depth_q;
    assign busy             = (state_q != IDLE);
    assign unsat            = (state_q == UNSAT);
    assign protocol_err     = perr_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_backtrack_ctrl.sv
// Directed bench for backtrack_ctrl with a behavioural formula stack.
module tb_backtrack_ctrl;
    import common::*;

    localparam int DEPTH   = formula_stack_size;
    localparam int DEPTH_W = width_formula_stack_size;

    logic             clock;
    logic             reset;
    logic             decide;
    logic             decide_second;
    logic             conflict;
    logic             stack_empty;
    formula           stack_dout;
    logic             stack_pop;
    logic             restore_valid;
    formula           restored_formula;
    logic [DEPTH_W:0] restore_level;
    logic [DEPTH_W:0] depth;
    logic             busy;
    logic             unsat;
    logic             protocol_err;
    logic [2:0]       dbg_state;

    formula           push_data;
    formula           mem [DEPTH];
    int               sp;

    int errors;
    int checks;

    backtrack_ctrl #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
        .clock            (clock),
        .reset            (reset),
        .decide           (decide),
        .decide_second    (decide_second),
        .conflict         (conflict),
        .stack_empty      (stack_empty),
        .stack_dout       (stack_dout),
        .stack_pop        (stack_pop),
        .restore_valid    (restore_valid),
        .restored_formula (restored_formula),
        .restore_level    (restore_level),
        .depth            (depth),
        .busy             (busy),
        .unsat            (unsat),
        .protocol_err     (protocol_err),
        .dbg_state        (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // behavioural formula stack, reset together with the controller
    always @(posedge clock) begin
        if (!reset) begin
            sp         <= 0;
            stack_dout <= zero_formula;
        end else if (stack_pop) begin
            stack_dout <= mem[sp-1];
            sp         <= sp - 1;
        end else if (decide && !conflict && sp < DEPTH) begin
            mem[sp] <= push_data;
            sp      <= sp + 1;
        end
    end
    assign stack_empty = (sp == 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic push(input formula f, input logic sec);
        decide        = 1'b1;
        decide_second = sec;
        push_data     = f;
        @(negedge clock);
        decide        = 1'b0;
        decide_second = 1'b0;
    endtask

    // conflict must already be driven; walks cycles 1..ncyc after the conflict edge
    task automatic run_bt(input int ncyc, input logic [15:0] pop_mask, input int restore_cyc,
                          input int unsat_cyc, input formula exp_f, input logic [DEPTH_W:0] exp_lvl);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clock);
            if (c == 1) begin
                conflict = 1'b0;
                decide   = 1'b0;
            end
            check($sformatf("pop_c%0d", c), 32'(stack_pop), 32'(pop_mask[c]));
            check($sformatf("rv_c%0d", c), 32'(restore_valid), 32'(c == restore_cyc));
            check($sformatf("unsat_c%0d", c), 32'(unsat), 32'(unsat_cyc != 0 && c >= unsat_cyc));
            check($sformatf("busy_c%0d", c), 32'(busy), 32'(restore_cyc == 0 || c <= restore_cyc));
            if (c == restore_cyc) begin
                check("restored_formula", 32'(restored_formula), 32'(exp_f));
                check("restore_level", 32'(restore_level), 32'(exp_lvl));
            end
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        decide        = 1'b0;
        decide_second = 1'b0;
        conflict      = 1'b0;
        push_data     = zero_formula;
        @(negedge clock);
        do_reset();

        // reset state
        check("rst_busy", 32'(busy), 0);
        check("rst_depth", 32'(depth), 0);
        check("rst_unsat", 32'(unsat), 0);
        check("rst_perr", 32'(protocol_err), 0);
        check("rst_rv", 32'(restore_valid), 0);
        check("rst_formula", 32'(restored_formula), 0);

        // 1: conflict at depth 0 -> UNSAT in cycle 1, no pop
        conflict = 1'b1;
        run_bt(3, 16'h0000, 0, 1, zero_formula, 0);

        // 2: single level, first branch -> restore in cycle 3
        do_reset();
        push(16'h1111, 1'b0);
        check("t2_depth", 32'(depth), 1);
        conflict = 1'b1;
        run_bt(4, 16'h0002, 3, 0, 16'h1111, 0);
        check("t2_depth_after", 32'(depth), 0);

        // 3: two exhausted levels above an open one
        do_reset();
        push(16'h1111, 1'b0);
        push(16'h2222, 1'b1);
        push(16'h3333, 1'b1);
        check("t3_depth", 32'(depth), 3);
        conflict = 1'b1;
        run_bt(8, 16'h002A, 7, 0, 16'h1111, 0);

        // 4: all levels exhausted -> UNSAT in cycle 5, later decide ignored
        do_reset();
        push(16'h1111, 1'b1);
        push(16'h2222, 1'b1);
        conflict = 1'b1;
        run_bt(6, 16'h000A, 0, 5, zero_formula, 0);
        push(16'h4444, 1'b0);
        check("t4_depth", 32'(depth), 0);
        check("t4_unsat", 32'(unsat), 1);
        check("t4_perr", 32'(protocol_err), 0);

        // 5a: saturated push rejected
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            push(formula'(16'h0100 + i), 1'b0);
        end
        check("t5_depth_full", 32'(depth), DEPTH);
        check("t5_perr_before", 32'(protocol_err), 0);
        push(16'hEEEE, 1'b0);
        check("t5_perr_sat", 32'(protocol_err), 1);
        check("t5_depth_sat", 32'(depth), DEPTH);

        // 5b: decide + conflict together at depth 2
        do_reset();
        push(16'hAAAA, 1'b0);
        push(16'hBBBB, 1'b0);
        conflict  = 1'b1;
        decide    = 1'b1;
        push_data = 16'hCCCC;
        @(negedge clock);
        conflict  = 1'b0;
        decide    = 1'b0;
        check("t5b_depth", 32'(depth), 2);
        check("t5b_perr", 32'(protocol_err), 1);
        check("t5b_pop", 32'(stack_pop), 1);
        @(negedge clock);
        check("t5b_depth_wait", 32'(depth), 1);
        @(negedge clock);
        check("t5b_rv", 32'(restore_valid), 1);
        check("t5b_formula", 32'(restored_formula), 32'h0000BBBB);
        check("t5b_level", 32'(restore_level), 1);
        @(negedge clock);
        check("t5b_idle", 32'(busy), 0);

        // 6: reset while in WAIT clears everything
        conflict = 1'b1;
        @(negedge clock);
        conflict = 1'b0;
        check("t6_pop", 32'(stack_pop), 1);
        @(negedge clock);
        check("t6_wait", 32'(dbg_state), 32'(WAIT));
        reset = 1'b0;
        @(negedge clock);
        check("t6_busy", 32'(busy), 0);
        check("t6_depth", 32'(depth), 0);
        check("t6_rv", 32'(restore_valid), 0);
        check("t6_formula", 32'(restored_formula), 0);
        check("t6_perr", 32'(protocol_err), 0);
        reset = 1'b1;
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/backtrack_ctrl.md
Name: backtrack_ctrl

Overview:
Read-side controller for the formula stack in the DPLL core. It mirrors every decision push and keeps a per-level "second branch already tried" flag. On a conflict it pops the formula stack until it reaches a level whose second branch is still open. It then hands the restored formula back to the solver, or declares UNSAT when no open level remains.

Parameters:
DEPTH, formula_stack_size, number of decision levels; must match the formula stack.
DEPTH_W, width_formula_stack_size, level index width; counters are DEPTH_W+1 bits.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
decide  in  1  solver pushes a formula this cycle; wired to the stack wr_en
decide_second  in  1  the pushed level is the second branch
conflict  in  1  one-cycle conflict pulse from the solver
stack_empty  in  1  stack empty flag; consistency check only
stack_dout  in  formula  stack pop data; valid the cycle after stack_pop
stack_pop  out  1  one-cycle pop request to the stack
restore_valid  out  1  one-cycle strobe; restored_formula and restore_level are valid
restored_formula  out  formula  formula to resume from, then take the second branch
restore_level  out  DEPTH_W+1  level count after the restore
depth  out  DEPTH_W+1  current level count; internal and authoritative
busy  out  1  state != IDLE
unsat  out  1  sticky; the search space is exhausted
protocol_err  out  1  sticky protocol violation

Behaviour:
- Reset (reset==0 at a clock edge, from any state):
  - State goes to IDLE.
  - depth=0; all flags=0; restored_formula=zero_formula.
  - All outputs 0.
  - The top level resets the formula stack in the same cycle.
- States: IDLE, POP, WAIT, RESTORE, UNSAT.
- IDLE, decide=1, conflict=0:
  - If depth<DEPTH: flag[depth]<=decide_second and depth<=depth+1.
  - Else: the push is ignored and protocol_err<=1.
- IDLE, conflict=1:
  - conflict has priority over decide.
  - If decide=1 in the same cycle, the push is ignored and protocol_err<=1.
  - If depth==0, go to UNSAT; otherwise go to POP.
- POP (1 cycle):
  - stack_pop=1; depth<=depth-1; latch flag[depth-1] into tried_r.
  - If stack_empty==1: protocol_err<=1, stack_pop is suppressed, go to UNSAT.
  - Otherwise go to WAIT.
- WAIT (1 cycle):
  - Capture stack_dout into restored_formula.
  - If tried_r==0, go to RESTORE.
  - Else if depth==0, go to UNSAT.
  - Else go to POP.
- RESTORE (1 cycle):
  - restore_valid=1 and restore_level=depth; go to IDLE.
  - The solver is then expected to push the second branch with decide_second=1.
- UNSAT: terminal. unsat=1, busy=1, all inputs ignored; only reset exits.
- decide or conflict while busy (POP/WAIT/RESTORE): ignored, protocol_err<=1.
- Latency, with conflict sampled at the end of cycle 0:
  - First pop in cycle 1; restore_valid in cycle 3.
  - Each additional exhausted level adds 2 cycles.
  - depth==0 at the conflict: unsat in cycle 1 with no pop.
- restored_formula holds its value until the next WAIT capture or reset.
- depth never wraps: saturated pushes are rejected, and pops occur only when depth>0.

Decomposition:
- Package common:
  - Existing: formula, zero_formula, formula_stack_size, width_formula_stack_size.
  - Add: enum bt_state_t {IDLE, POP, WAIT, RESTORE, UNSAT}.
- Sub-module branch_flag_stack:
  - DEPTH x 1-bit register array.
  - Write port at index depth on push; combinational read at depth-1.
  - Synchronous active-low reset clears all bits.

Test Plan:
1. Reset, then conflict with depth=0 -> unsat=1 from cycle 1, stack_pop never asserts, busy=1.
2. Push F1 (second=0), then conflict -> stack_pop in cycle 1; cycle 3 restore_valid=1, restored_formula=F1, restore_level=0; IDLE in cycle 4.
3. Push F1(0), F2(1), F3(1), then conflict -> stack_pop in cycles 1, 3, 5; restore_valid in cycle 7 with F1, restore_level=0.
4. Push F1(1), F2(1), then conflict -> pops in cycles 1 and 3; unsat=1 in cycle 5; a later decide is ignored and depth stays 0.
5. Push DEPTH levels, then decide -> protocol_err=1, depth=DEPTH. Separately: decide+conflict in one cycle at depth=2 -> depth stays 2 before the pop, protocol_err=1, and the conflict is processed.
6. reset=0 during WAIT -> next cycle busy=0, depth=0, restore_valid=0, restored_formula=zero_formula, protocol_err=0.
